uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: oversampled start/data/stop detection, configurable word
//  width and stop bits, per-word framing/parity status, small receive FIFO with a
//  valid/ready output. Sits between the rx pad and the system-clock consumer.
// PARAMETERS
//  pBAUD_RATE     9600       line bit rate, bits/s
//  pSYS_CLK_FREQ  100000000  sys_clk frequency, Hz
//  pOVERSAMPLE    16         sample ticks per bit; even, >= 8
//  pDATA_BITS     8          data bits per frame, 5..9
//  pSTOP_BITS     1          stop bits, 1 or 2
//  pPARITY_ODD    0          0 = even parity, 1 = odd (used only with UART_RX_PARITY_EN)
//  pFIFO_DEPTH    4          receive FIFO entries, power of 2, >= 2
// PORTS
//  sys_clk     in   1                        system clock, rising edge
//  rst         in   1                        asynchronous reset, active high
//  rx          in   1                        serial line, idle high, asynchronous
//  data_out    out  pDATA_BITS               FIFO head data word
//  data_valid  out  1                        FIFO non-empty; data_out/flags valid
//  data_ready  in   1                        consumer accepts head word this cycle
//  frame_err   out  1                        head word: a stop bit sampled low
//  parity_err  out  1                        head word: parity mismatch (0 if no parity)
//  overrun     out  1                        1-cycle pulse: frame dropped, FIFO full
//  fifo_count  out  $clog2(pFIFO_DEPTH)+1    entries held
// BEHAVIOUR
//  - Reset: data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0,
//    fifo_count=0; synchroniser flops = 1; FSM = IDLE; tick/bit counters = 0.
//  - rx passes a 2-flop synchroniser (2 cycles latency) before any use.
//  - Tick: DIV = pSYS_CLK_FREQ/(pBAUD_RATE*pOVERSAMPLE), integer floor, min 1;
//    counter 0..DIV-1, one-cycle tick at wrap; free-running; restarted on start detect.
//  - FSM: IDLE -> START on synchronised rx 1->0. START: after pOVERSAMPLE/2 ticks
//    sample; rx=1 -> IDLE (false start, nothing pushed); rx=0 -> DATA.
//    DATA: sample every pOVERSAMPLE ticks, pDATA_BITS bits, LSB first.
//    PARITY (macro only): one sample. STOP: pSTOP_BITS samples; any 0 sets frame_err.
//    After last stop sample: push {flags,data} and go to IDLE in the same cycle;
//    rx still low there (break) is not a new start until rx returns high.
//  - Latency: pushed word visible (data_valid=1) the cycle after the last stop sample.
//  - FIFO: pop when data_valid & data_ready. Push when full is dropped and overrun
//    pulses for 1 cycle, unless pop in the same cycle (then push accepted, count
//    unchanged). Push+pop when empty: word stored, count ends at 1.
//  - data_out/frame_err/parity_err are registered head contents, stable while
//    data_valid=1 and data_ready=0.
//  - Reset mid-frame or with FIFO non-empty: partial frame discarded, FIFO emptied.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, one bit after data; parity_err=1
//    when XOR(data,parity bit) != pPARITY_ODD.
//  Not defined: no parity bit expected, STOP follows DATA; parity_err tied 0.
// TESTING (defaults, 100 MHz: DIV=651, bit time 104160 ns)
//  1. Frame 0x59 (bits 1,0,0,1,1,0,1,0), stop=1, data_ready=1 -> data_out=0x59,
//     data_valid 1 cycle, frame_err=0, parity_err=0, fifo_count back to 0.
//  2. 0.3-bit low glitch on idle rx -> no push, FSM back to IDLE; following 0xA5
//     frame received correctly.
//  3. Frame 0x3C with stop bit driven 0 -> data_out=0x3C, frame_err=1; next good
//     frame 0x01 -> frame_err=0.
//  4. UART_RX_PARITY_EN, even: 0x07 with parity 1 -> parity_err=0; with parity 0
//     -> parity_err=1.
//  5. data_ready=0, five frames 0x10..0x14 -> fifo_count=4, overrun pulses once
//     on fifth; then ready=1 pops 0x10,0x11,0x12,0x13 in order.
//  6. rst pulse mid-DATA of a frame, FIFO holding 2 words -> all outputs at reset
//     values; next full frame 0x5A received normally.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with a small valid/ready receive FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
   parameter int pBAUD_RATE    = 9600,
   parameter int pSYS_CLK_FREQ = 100000000,
   parameter int pOVERSAMPLE   = 16,
   parameter int pDATA_BITS    = 8,
   parameter int pSTOP_BITS    = 1,
   parameter int pPARITY_ODD   = 0,
   parameter int pFIFO_DEPTH   = 4
) (
   input  logic                           sys_clk,
   input  logic                           rst,
   input  logic                           rx,
   output logic [pDATA_BITS-1:0]          data_out,
   output logic                           data_valid,
   input  logic                           data_ready,
   output logic                           frame_err,
   output logic                           parity_err,
   output logic                           overrun,
   output logic [$clog2(pFIFO_DEPTH):0]   fifo_count
);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam int DIV_RAW = pSYS_CLK_FREQ / (pBAUD_RATE * pOVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OSW     = $clog2(pOVERSAMPLE);
   localparam int PW      = $clog2(pFIFO_DEPTH);
   localparam int CW      = PW + 1;
   localparam int W       = pDATA_BITS + 2;

   localparam logic [TW-1:0]  T_LAST  = TW'(DIV - 1);
   localparam logic [OSW-1:0] OS_HALF = OSW'(pOVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(pOVERSAMPLE - 1);
   localparam logic [3:0]     D_LAST  = 4'(pDATA_BITS - 1);
   localparam logic [3:0]     S_LAST  = 4'(pSTOP_BITS - 1);
   localparam logic           PODD    = (pPARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t state_q, state_d;

   logic                  rx_s1_q, rx_s2_q, rx_prev_q;
   logic [TW-1:0]         tick_cnt_q;
   logic [OSW-1:0]        os_cnt_q;
   logic [3:0]            bit_cnt_q;
   logic [pDATA_BITS-1:0] shift_q;
   logic                  par_q;
   logic                  ferr_q;

   logic tick, fall, start_det;
   logic sample, last_bit, push;
   logic ferr_w, perr_w;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Edge-based start: a line held low after a frame never retriggers.
   assign fall      = rx_prev_q & ~rx_s2_q;
   assign start_det = (state_q == IDLE) & fall;
   assign tick      = (tick_cnt_q == T_LAST);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (fall) state_d = START;
         START:  if (sample) state_d = rx_s2_q ? IDLE : DATA;
         DATA:   if (sample && last_bit) state_d = PAR_EN ? PARITY : STOP;
         PARITY: if (sample) state_d = STOP;
         STOP:   if (sample && last_bit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sample   = 1'b0;
      last_bit = 1'b0;
      unique case (state_q)
         START:  sample = tick & (os_cnt_q == OS_HALF);
         DATA: begin
            sample   = tick & (os_cnt_q == OS_LAST);
            last_bit = (bit_cnt_q == D_LAST);
         end
         PARITY: begin
            sample   = tick & (os_cnt_q == OS_LAST);
            last_bit = 1'b1;
         end
         STOP: begin
            sample   = tick & (os_cnt_q == OS_LAST);
            last_bit = (bit_cnt_q == S_LAST);
         end
         default: ;
      endcase
      push = (state_q == STOP) & sample & last_bit;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         tick_cnt_q <= (start_det | tick) ? '0 : tick_cnt_q + TW'(1);
         if (start_det | sample) os_cnt_q <= '0;
         else if (tick)          os_cnt_q <= os_cnt_q + OSW'(1);
         if (state_d != state_q) bit_cnt_q <= '0;
         else if (sample)        bit_cnt_q <= bit_cnt_q + 4'd1;
         if (sample && state_q == DATA)
            shift_q <= {rx_s2_q, shift_q[pDATA_BITS-1:1]};
         if (sample && state_q == PARITY)
            par_q <= rx_s2_q;
         if (start_det)
            ferr_q <= 1'b0;
         else if (sample && state_q == STOP && !rx_s2_q)
            ferr_q <= 1'b1;
      end
   end

   // Include the final stop sample, which lands in the push cycle.
   assign ferr_w = ferr_q | ~rx_s2_q;
   assign perr_w = PAR_EN & ((^shift_q ^ par_q) != PODD);

   logic [W-1:0]  mem_q [pFIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovr_q;
   logic          full, pop, wr_en;
   logic [W-1:0]  head;

   assign full  = (count_q == CW'(pFIFO_DEPTH));
   assign pop   = (count_q != '0) & data_ready;
   assign wr_en = push & (~full | pop);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < pFIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= {perr_w, ferr_w, shift_q};
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(wr_en) - CW'(pop);
         ovr_q   <= push & full & ~pop;
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign data_out   = head[pDATA_BITS-1:0];
   assign frame_err  = head[pDATA_BITS];
   assign parity_err = PAR_EN & head[pDATA_BITS+1];
   assign data_valid = (count_q != '0);
   assign overrun    = ovr_q;
   assign fifo_count = count_q;

endmodule
